// File: rtl/bv4_theta_expand.sv
// bv4_theta_expand: back-end of the GF(2^4) tower-field inverter.
// Expands Gamma (GF(2^4), normal basis) and its norm inverse Theta (GF(2^2))
// into Gamma^-1 = {Theta*a[0], Theta*a[1]} behind a valid/ready pipeline.
//
// Ports:
//   in_clk, in_rst_n      clock, asynchronous active-low reset
//   in_a[3:0]             Gamma, a[1] = in_a[3:2], a[0] = in_a[1:0]
//   in_theta[1:0]         Theta for the same in_a
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   out_b[3:0]            Gamma^-1, registered
//   out_valid / out_ready output handshake
//
// Build option BV4_THETA_EXPAND_REG_IN_EN: adds the S1 operand register so the
// multipliers sit between registers (latency 2, capacity 2). Without it the
// inputs feed the multipliers straight into S2 (latency 1, capacity 1).
module bv4_theta_expand (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [3:0] in_a,
    input  logic [1:0] in_theta,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_b,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int unsigned GW = 2;
    localparam int unsigned BW = 4;

    // GF(2^2) multiply in normal basis {W^2, W}; 2'b11 is the unit element
    function automatic logic [GW-1:0] gf4_mul(input logic [GW-1:0] x, input logic [GW-1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    logic          s2_ready;
    logic [BW-1:0] mul_a;
    logic [GW-1:0] mul_theta;
    logic          mul_valid;
    logic [BW-1:0] product;

    // S2 can take new data when empty or when its content leaves this cycle
    assign s2_ready = !out_valid || out_ready;

    // Gamma = 0 yields zero products naturally, so no special case is needed
    assign product = {gf4_mul(mul_theta, mul_a[1:0]), gf4_mul(mul_theta, mul_a[3:2])};

`ifdef BV4_THETA_EXPAND_REG_IN_EN
    logic [BW-1:0] s1_a;
    logic [GW-1:0] s1_theta;
    logic          s1_valid;

    // S1 accepts when empty or when it drains into S2 in the same cycle
    assign in_ready = !s1_valid || s2_ready;

    // S1 operand register
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_theta <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= in_a;
                s1_theta <= in_theta;
            end
        end
    end

    assign mul_a     = s1_a;
    assign mul_theta = s1_theta;
    assign mul_valid = s1_valid;
`else
    assign in_ready  = s2_ready;
    assign mul_a     = in_a;
    assign mul_theta = in_theta;
    assign mul_valid = in_valid;
`endif

    // S2 product register; only loads when free, so out_b holds while stalled
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_valid <= 1'b0;
            out_b     <= '0;
        end else if (s2_ready) begin
            out_valid <= mul_valid;
            if (mul_valid) begin
                out_b <= product;
            end
        end
    end

endmodule

// File: doc/bv4_theta_expand.md
# bv4_theta_expand

Pipelined back-end of the GF(2^4) tower-field inverter in the AES S-box datapath. Receives the GF(2^4) operand Gamma together with its already-computed norm inverse Theta (GF(2^2)) and expands them into the GF(2^4) inverse Gamma^{-1}. It sits directly downstream of the Theta computation and upstream of the GF(2^8) recombination multipliers. Transfers use a valid/ready handshake with full back-pressure support.

## Interface
- No parameters. Structure is fixed: normal basis, bv2_t/bv4_t types from aes128_package.
- in_clk  input  1  clock; all state updates on the rising edge
- in_rst_n  input  1  reset, asynchronous, active-low
- in_a  input  4  Gamma as bv2_t[1:0]; a[1] = in_a[3:2], a[0] = in_a[1:0]
- in_theta  input  2  Theta = (a[1]*a[0] + (a[1]^a[0])^2 * Sigma)^{-1}, computed for the same in_a
- in_valid  input  1  in_a/in_theta are valid
- in_ready  output  1  block accepts an input this cycle
- out_b  output  4  Gamma^{-1}
- out_valid  output  1  out_b is valid
- out_ready  input  1  downstream accepts out_b

## Operation
- Arithmetic uses GF(2^2) in normal basis {W^2, W}. The field element 1 is encoded as 2'b11.
- out_b[3:2] = Theta * a[0] and out_b[1:0] = Theta * a[1], both computed with the team's bv2 multiplier.
- Zero maps to zero: Gamma = 0 gives out_b = 0 regardless of Theta.
- Pipeline holds up to 2 entries:
  - Stage S1 (operand register, present only with the macro): holds a and Theta.
  - Stage S2 (product register): holds out_b.
- Each stage has a valid bit. A stage advances when its own valid is 0, or when the next stage consumes its content in the same cycle.
- Handshake rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready is combinational: high when S1 (or S2 without the macro) is empty, or when that stage is draining this cycle.
  - No bubble on a simultaneous push and pop when full: throughput is 1 per cycle.
  - Once out_valid is asserted, out_b is stable until the transfer completes.
  - in_a and in_theta are sampled only on an accepted transfer.
- Ordering is strict FIFO. No entry is dropped or duplicated.

## Timing
- Reset (asynchronous assertion, synchronous-to-clock release):
  - All valid bits clear, so out_valid = 0.
  - out_b = 4'h0 and all data registers = 0.
  - in_ready = 1 in the first cycle after release.
- Latency from input transfer to out_valid:
  - 2 cycles with the macro.
  - 1 cycle without it.
- Reset asserted mid-operation discards all in-flight entries immediately. out_valid drops asynchronously.
- out_ready low with the pipeline full: in_ready = 0 and all state is held.
- out_ready low while only S2 is full: S1 may still accept one entry, then in_ready = 0.
- No combinational path from in_a/in_theta to out_b. The only combinational path from out_ready is to in_ready.

## Configuration
- BV4_THETA_EXPAND_REG_IN_EN
  - Defined: S1 operand register is instantiated. Latency 2, capacity 2, multipliers sit between registers, which eases timing after the Theta logic.
  - Undefined: inputs feed the multipliers directly into S2. Latency 1, capacity 1, in_ready = !out_valid || out_ready.
- Handshake semantics and the arithmetic result are identical in both builds.

## Test plan
- Reset: hold in_rst_n = 0 with random inputs -> out_valid = 0, out_b = 4'h0. After release, in_ready = 1.
- Identity: in_a = 4'hF, in_theta = 2'b11, out_ready = 1 -> out_b = 4'hF after 2 cycles (1 without the macro).
- Known product: in_a = 4'hB, in_theta = 2'b11 -> out_b = 4'hE. Also in_a = 4'h0, in_theta = 2'b01 -> out_b = 4'h0.
- Exhaustive chain: all 16 in_a values, with in_theta produced by the Theta block, streamed back-to-back -> out_b * in_a = 4'hF for every nonzero in_a and 4'h0 for in_a = 0. Order preserved, one output per cycle.
- Back-pressure: stream 4'h1, 4'h2, 4'h3 with out_ready = 0 -> in_ready falls after 2 accepts (1 without the macro) and out_b holds the first result. Raise out_ready -> results emerge in order with no loss or duplication.
- Mid-stream reset: pipeline full, pulse in_rst_n low asynchronously between edges -> out_valid = 0 immediately. After release, the next input is the first output.
